// File: rtl/comp_popcnt_pipe.sv
// Pipelined population-count column compressor with valid-qualified streaming
// and an optional saturating per-frame accumulator.
module comp_popcnt_pipe #(
    parameter int IN_W   = 256,
    parameter int STAGES = 3,
    parameter int ACC_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [IN_W-1:0]           in_col,
    input  logic                      in_last,
    input  logic                      acc_en,
    output logic                      out_valid,
    output logic [$clog2(IN_W+1)-1:0] comp_out,
    output logic                      acc_valid,
    output logic [ACC_W-1:0]          acc_out,
    output logic                      acc_ovf
);
    localparam int OUT_W  = $clog2(IN_W + 1);
    localparam int LEVELS = $clog2(IN_W);

    function automatic int node_cnt(input int lvl);
        return (IN_W + (1 << lvl) - 1) >> lvl;
    endfunction

    // Number of tree registers passed once adder level lvl is done; a level
    // gets a register whenever this value steps, spreading STAGES evenly.
    function automatic int stage_of(input int lvl);
        return (lvl * STAGES) / LEVELS;
    endfunction

    logic [IN_W-1:0] col_q;
    logic [STAGES:0] vld_p;
    logic [STAGES:0] last_p;
    logic [STAGES:0] acc_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            vld_p  <= '0;
            last_p <= '0;
            acc_p  <= '0;
        end else begin
            col_q  <= in_col;
            vld_p  <= {vld_p[STAGES-1:0], in_valid};
            last_p <= {last_p[STAGES-1:0], in_last};
            acc_p  <= {acc_p[STAGES-1:0], acc_en};
        end
    end

    // Binary adder tree; every node is OUT_W wide since no partial sum can exceed IN_W.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int NODES = node_cnt(l);
        logic [OUT_W-1:0] q [NODES];

        if (l == 0) begin : g_leaf
            always_comb begin
                for (int i = 0; i < NODES; i++) begin
                    q[i] = OUT_W'(col_q[i]);
                end
            end
        end else begin : g_add
            localparam int PREV = node_cnt(l - 1);
            localparam int SIDX = stage_of(l);
            localparam bit REG  = (stage_of(l) != stage_of(l - 1));
            logic [OUT_W-1:0] pad [2*NODES];
            logic [OUT_W-1:0] sum [NODES];

            always_comb begin
                for (int j = 0; j < 2*NODES; j++) begin
                    pad[j] = '0;
                end
                for (int j = 0; j < PREV; j++) begin
                    pad[j] = g_lvl[l-1].q[j];
                end
                for (int i = 0; i < NODES; i++) begin
                    sum[i] = pad[2*i] + pad[2*i+1];
                end
            end

            if (REG) begin : g_reg
                // Loads only for a live beat, so the last level holds comp_out when idle.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        q <= '{default: '0};
                    end else if (vld_p[SIDX-1]) begin
                        q <= sum;
                    end
                end
            end else begin : g_comb
                always_comb begin
                    q = sum;
                end
            end
        end
    end

    assign out_valid = vld_p[STAGES];
    assign comp_out  = g_lvl[LEVELS].q[0];

    logic [ACC_W-1:0] sum_q;
    logic             ovf_q;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_sat;
    logic             clamp;
    logic             take;

    always_comb begin
        take     = out_valid && acc_p[STAGES];
        sum_wide = {1'b0, sum_q} + (ACC_W+1)'(comp_out);
        clamp    = sum_wide[ACC_W];
        sum_sat  = clamp ? '1 : sum_wide[ACC_W-1:0];
    end

    // A closing beat publishes the frame result and restarts the sum in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            acc_valid <= 1'b0;
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            acc_valid <= 1'b0;
            if (take) begin
                if (last_p[STAGES]) begin
                    acc_valid <= 1'b1;
                    acc_out   <= sum_sat;
                    acc_ovf   <= ovf_q | clamp;
                    sum_q     <= '0;
                    ovf_q     <= 1'b0;
                end else begin
                    sum_q <= sum_sat;
                    ovf_q <= ovf_q | clamp;
                end
            end
        end
    end

endmodule
